mkio_channel_arbiter: RTL and testbench
=======================================

// Module: mkio_channel_arbiter
// PURPOSE
// - Dual-redundant 1553B bus selector. Sits between the channel A/B Manchester word decoders/encoders and the RT protocol core.
// - Locks onto the channel carrying the current command. Forwards that channel's words to the core. Routes the core's reply to the same encoder.
// - A valid command on the other channel supersedes the current transaction (1553B rule).
// PARAMETERS
// - GAP_CLKS  64  idle clocks on the locked channel before the lock is released (64 = 2 us at 32 MHz)
// - GAP_W     7   width of the gap counter; must hold GAP_CLKS
// PORTS
// - clk           in   1   system clock, 32 MHz
// - reset         in   1   async, active-low (0 = reset)
// - rxa_valid     in   1   1-clk pulse: channel A decoder has a word
// - rxa_sync      in   1   A word type: 1 = command/status sync, 0 = data sync
// - rxa_par_ok    in   1   A word parity good
// - rxa_data      in   16  A word payload
// - rxb_valid, rxb_sync, rxb_par_ok, rxb_data   in  1/1/1/16  same fields for channel B
// - word_valid    out  1   1-clk pulse to the RT core
// - word_sync     out  1   forwarded sync type
// - word_data     out  16  forwarded payload
// - active_chan   out  1   0 = A, 1 = B; valid while locked
// - locked        out  1   a transaction is in progress
// - tx_req        in   1   core requests a reply transmission (level; held until tx_done)
// - tx_done       in   1   1-clk pulse: encoder finished the last word
// - tx_en_a       out  1   enable channel A encoder
// - tx_en_b       out  1   enable channel B encoder
// - TX_INHIBIT_A  out  1   transceiver inhibit, channel A
// - TX_INHIBIT_B  out  1   transceiver inhibit, channel B
// - abort         out  1   1-clk pulse: current transaction superseded; core must discard it
// - gap_timeout   out  1   1-clk pulse: lock released on gap expiry
// BEHAVIOUR
// - Reset: state=IDLE; active_chan=0; locked=0; word_valid=0; word_sync=0; word_data=0; tx_en_a=0; tx_en_b=0; abort=0; gap_timeout=0; TX_INHIBIT_A=1; TX_INHIBIT_B=1.
// - "Good cmd" on channel X = rxX_valid & rxX_sync & rxX_par_ok. Words with par_ok=0 are never forwarded.
// - Latency: an accepted word appears on word_* exactly 1 clk after its rxX_valid.
// - IDLE
//   - Good cmd on A or B: lock that channel, forward the word, go to RX.
//   - Both channels present a good cmd in the same clk: A wins; B's word is dropped.
//   - Data words and bad words are dropped.
// - RX
//   - Valid, parity-good words from the locked channel are forwarded.
//   - Gap counter clears on every locked-channel rxX_valid and increments otherwise.
//   - Gap counter reaches GAP_CLKS-1: pulse gap_timeout; locked=0; go to IDLE.
//   - tx_req=1: go to TX (1 clk later tx_en of the locked channel = 1).
// - TX
//   - tx_en of the locked channel = 1; the other tx_en = 0.
//   - TX_INHIBIT of the locked channel = 0; the other = 1. Both inhibits = 1 in every other state.
//   - Gap counter is held at 0.
//   - tx_done: tx_en drops; go to IDLE; locked=0.
// - Supersede, in RX or TX
//   - Good cmd on the non-locked channel: pulse abort, drop tx_en/inhibit, switch active_chan, forward the new cmd.
//   - Stay or return to RX with the gap counter at 0.
//   - Good cmd on the locked channel in RX is forwarded as a normal word (no abort).
// - Simultaneous events
//   - Supersede beats tx_req and tx_done in the same clk.
//   - tx_req beats gap expiry in the same clk.
// - Reset asserted mid-transaction: outputs return to reset values immediately (async); no abort pulse.
// CONFIGURATION
// - MKIO_ARB_STATS_EN defined: adds outputs stat_abort[15:0], stat_timeout[15:0], stat_drop[15:0].
//   - Incremented on abort, gap_timeout, and each dropped valid word respectively.
//   - Each counter saturates at 16'hFFFF and clears on reset.
// - MKIO_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
// - Cmd 16'h0867 on A (good) then 7 data words on A -> 8 word_valid pulses, each 1 clk late; active_chan=0; no abort.
// - Good cmd on A and on B in the same clk -> A locked; only A's word is forwarded; stat_drop=1 if stats enabled.
// - Lock A, then no further words -> gap_timeout pulses 64 clks after the last rxa_valid; locked=0; both inhibits=1.
// - Lock A, tx_req=1 -> next clk tx_en_a=1, TX_INHIBIT_A=0, TX_INHIBIT_B=1; tx_done -> IDLE, both inhibits=1.
// - In TX on A, good cmd 16'h0C25 on B -> abort pulse; tx_en_a=0; active_chan=1; word_data=16'h0C25.
// - Lock A, good cmd with par_ok=0 on B -> no abort, word dropped; reset pulse mid-RX -> all outputs at reset values.

Source files
------------

// File: rtl/mkio_channel_arbiter.sv
// Dual-redundant 1553B channel arbiter: locks to the commanding bus, forwards
// its words to the RT core and steers the reply encoder to the same bus.
//
// Ports:
//   clk, reset (async, active-low)
//   rxa_* / rxb_*  : decoder words from channel A / B (valid, sync, par_ok, data)
//   word_*         : forwarded word to the RT core (1 clk after rx valid)
//   active_chan    : 0 = A, 1 = B;  locked : transaction in progress
//   tx_req/tx_done : core reply handshake
//   tx_en_a/b, TX_INHIBIT_A/B : encoder enables and transceiver inhibits
//   abort          : transaction superseded by a command on the other bus
//   gap_timeout    : lock released after GAP_CLKS idle clocks
// Optional build macro MKIO_ARB_STATS_EN adds stat_abort/stat_timeout/stat_drop.
module mkio_channel_arbiter #(
  parameter int GAP_CLKS = 64,
  parameter int GAP_W    = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxa_valid,
  input  logic        rxa_sync,
  input  logic        rxa_par_ok,
  input  logic [15:0] rxa_data,
  input  logic        rxb_valid,
  input  logic        rxb_sync,
  input  logic        rxb_par_ok,
  input  logic [15:0] rxb_data,
  output logic        word_valid,
  output logic        word_sync,
  output logic [15:0] word_data,
  output logic        active_chan,
  output logic        locked,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        tx_en_a,
  output logic        tx_en_b,
  output logic        TX_INHIBIT_A,
  output logic        TX_INHIBIT_B,
  output logic        abort,
`ifdef MKIO_ARB_STATS_EN
  output logic [15:0] stat_abort,
  output logic [15:0] stat_timeout,
  output logic [15:0] stat_drop,
`endif
  output logic        gap_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2
  } state_t;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

  state_t           state, nxt_state;
  logic             nxt_chan;
  logic [GAP_W-1:0] gap, nxt_gap;
  logic             nxt_abort, nxt_to;
  logic             fwd_a, fwd_b;

  logic good_a, good_b;
  logic lock_v, lock_par, other_good;

  assign good_a = rxa_valid & rxa_sync & rxa_par_ok;
  assign good_b = rxb_valid & rxb_sync & rxb_par_ok;

  assign lock_v     = active_chan ? rxb_valid  : rxa_valid;
  assign lock_par   = active_chan ? rxb_par_ok : rxa_par_ok;
  assign other_good = active_chan ? good_a     : good_b;

  always_comb begin
    nxt_state = state;
    nxt_chan  = active_chan;
    nxt_gap   = gap;
    nxt_abort = 1'b0;
    nxt_to    = 1'b0;
    fwd_a     = 1'b0;
    fwd_b     = 1'b0;
    unique case (state)
      IDLE: begin
        nxt_gap = '0;
        if (good_a) begin
          fwd_a     = 1'b1;
          nxt_chan  = 1'b0;
          nxt_state = RX;
        end else if (good_b) begin
          fwd_b     = 1'b1;
          nxt_chan  = 1'b1;
          nxt_state = RX;
        end
      end
      RX: begin
        if (other_good) begin
          // command on the other bus supersedes this transaction
          nxt_abort = 1'b1;
          nxt_chan  = ~active_chan;
          fwd_a     = active_chan;
          fwd_b     = ~active_chan;
          nxt_gap   = '0;
        end else begin
          if (lock_v) begin
            nxt_gap = '0;
            fwd_a   = ~active_chan & lock_par;
            fwd_b   = active_chan & lock_par;
          end else begin
            nxt_gap = gap + 1'b1;
          end
          if (tx_req) begin
            nxt_state = TX;
            nxt_gap   = '0;
          end else if (!lock_v && gap == GAP_LAST) begin
            nxt_to    = 1'b1;
            nxt_state = IDLE;
            nxt_gap   = '0;
          end
        end
      end
      TX: begin
        nxt_gap = '0;
        if (other_good) begin
          nxt_abort = 1'b1;
          nxt_chan  = ~active_chan;
          fwd_a     = active_chan;
          fwd_b     = ~active_chan;
          nxt_state = RX;
        end else if (tx_done) begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      active_chan <= 1'b0;
      gap         <= '0;
      word_valid  <= 1'b0;
      word_sync   <= 1'b0;
      word_data   <= '0;
      abort       <= 1'b0;
      gap_timeout <= 1'b0;
    end else begin
      state       <= nxt_state;
      active_chan <= nxt_chan;
      gap         <= nxt_gap;
      word_valid  <= fwd_a | fwd_b;
      abort       <= nxt_abort;
      gap_timeout <= nxt_to;
      if (fwd_a) begin
        word_sync <= rxa_sync;
        word_data <= rxa_data;
      end else if (fwd_b) begin
        word_sync <= rxb_sync;
        word_data <= rxb_data;
      end
    end
  end

  assign locked       = (state != IDLE);
  assign tx_en_a      = (state == TX) & ~active_chan;
  assign tx_en_b      = (state == TX) & active_chan;
  assign TX_INHIBIT_A = ~tx_en_a;
  assign TX_INHIBIT_B = ~tx_en_b;

`ifdef MKIO_ARB_STATS_EN
  logic        drop_a, drop_b;
  logic [16:0] drop_sum;

  assign drop_a   = rxa_valid & ~fwd_a;
  assign drop_b   = rxb_valid & ~fwd_b;
  assign drop_sum = {1'b0, stat_drop} + {16'd0, drop_a} + {16'd0, drop_b};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_abort   <= '0;
      stat_timeout <= '0;
      stat_drop    <= '0;
    end else begin
      if (nxt_abort && stat_abort != 16'hFFFF)
        stat_abort <= stat_abort + 16'd1;
      if (nxt_to && stat_timeout != 16'hFFFF)
        stat_timeout <= stat_timeout + 16'd1;
      stat_drop <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_mkio_channel_arbiter.sv
// Directed self-checking bench for mkio_channel_arbiter.
// Inputs change 1 ns after posedge; outputs are sampled there as well.
module tb_mkio_channel_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxa_valid, rxa_sync, rxa_par_ok;
  logic [15:0] rxa_data;
  logic        rxb_valid, rxb_sync, rxb_par_ok;
  logic [15:0] rxb_data;
  logic        word_valid, word_sync;
  logic [15:0] word_data;
  logic        active_chan, locked;
  logic        tx_req, tx_done;
  logic        tx_en_a, tx_en_b, TX_INHIBIT_A, TX_INHIBIT_B;
  logic        abort, gap_timeout;
`ifdef MKIO_ARB_STATS_EN
  logic [15:0] stat_abort, stat_timeout, stat_drop;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mkio_channel_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .rxa_valid    (rxa_valid),
    .rxa_sync     (rxa_sync),
    .rxa_par_ok   (rxa_par_ok),
    .rxa_data     (rxa_data),
    .rxb_valid    (rxb_valid),
    .rxb_sync     (rxb_sync),
    .rxb_par_ok   (rxb_par_ok),
    .rxb_data     (rxb_data),
    .word_valid   (word_valid),
    .word_sync    (word_sync),
    .word_data    (word_data),
    .active_chan  (active_chan),
    .locked       (locked),
    .tx_req       (tx_req),
    .tx_done      (tx_done),
    .tx_en_a      (tx_en_a),
    .tx_en_b      (tx_en_b),
    .TX_INHIBIT_A (TX_INHIBIT_A),
    .TX_INHIBIT_B (TX_INHIBIT_B),
    .abort        (abort),
`ifdef MKIO_ARB_STATS_EN
    .stat_abort   (stat_abort),
    .stat_timeout (stat_timeout),
    .stat_drop    (stat_drop),
`endif
    .gap_timeout  (gap_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_rx();
    rxa_valid = 0; rxa_sync = 0; rxa_par_ok = 0; rxa_data = '0;
    rxb_valid = 0; rxb_sync = 0; rxb_par_ok = 0; rxb_data = '0;
  endtask

  task automatic drive_a(input logic s, input logic p, input logic [15:0] d);
    rxa_valid = 1; rxa_sync = s; rxa_par_ok = p; rxa_data = d;
  endtask

  task automatic drive_b(input logic s, input logic p, input logic [15:0] d);
    rxb_valid = 1; rxb_sync = s; rxb_par_ok = p; rxb_data = d;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_chan"}, active_chan, 0);
    check({tag, "_wv"}, word_valid, 0);
    check({tag, "_wd"}, word_data, 0);
    check({tag, "_ws"}, word_sync, 0);
    check({tag, "_txen"}, {tx_en_a, tx_en_b}, 2'b00);
    check({tag, "_inh"}, {TX_INHIBIT_A, TX_INHIBIT_B}, 2'b11);
    check({tag, "_abort"}, abort, 0);
    check({tag, "_gto"}, gap_timeout, 0);
  endtask

  initial begin
    int pulses;
    int cnt;
    idle_rx();
    tx_req = 0; tx_done = 0;
    reset = 0;
    tick(); tick();
    check_reset_outs("rst");
    reset = 1;
    tick();

    // command + 7 data words on A, each forwarded 1 clk later
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive_a(i == 0, 1'b1, 16'h0867 + 16'(i));
      tick();
      if (word_valid) pulses++;
      check($sformatf("seq_wd%0d", i), word_data, 16'h0867 + 16'(i));
      check($sformatf("seq_ws%0d", i), word_sync, (i == 0));
      check($sformatf("seq_ab%0d", i), abort, 0);
    end
    idle_rx();
    check("seq_pulses", pulses, 8);
    check("seq_chan", active_chan, 0);

    // gap expiry 64 clks after the last rxa_valid edge
    cnt = 0;
    while (!gap_timeout && cnt < 200) begin
      tick();
      cnt++;
    end
    check("gap_clks", cnt, 64);
    check("gap_unlock", locked, 0);
    check("gap_inh", {TX_INHIBIT_A, TX_INHIBIT_B}, 2'b11);
    tick();
    check("gap_pulse_end", gap_timeout, 0);

    // simultaneous good commands: A wins
    drive_a(1, 1, 16'h1111);
    drive_b(1, 1, 16'h2222);
    tick();
    idle_rx();
    check("sim_wv", word_valid, 1);
    check("sim_wd", word_data, 16'h1111);
    check("sim_chan", active_chan, 0);
    check("sim_locked", locked, 1);
`ifdef MKIO_ARB_STATS_EN
    check("sim_drop", stat_drop, 1);
    check("sim_to", stat_timeout, 1);
`endif
    tick();
    check("sim_wv_end", word_valid, 0);

    // reply on A
    tx_req = 1;
    tick();
    check("tx_en", {tx_en_a, tx_en_b}, 2'b10);
    check("tx_inh", {TX_INHIBIT_A, TX_INHIBIT_B}, 2'b01);
    tick(); tick();
    check("tx_hold", tx_en_a, 1);
    check("tx_no_gto", gap_timeout, 0);
    tx_done = 1; tx_req = 0;
    tick();
    tx_done = 0;
    check("txd_en", {tx_en_a, tx_en_b}, 2'b00);
    check("txd_lock", locked, 0);
    check("txd_inh", {TX_INHIBIT_A, TX_INHIBIT_B}, 2'b11);

    // supersede during TX on A by a command on B
    drive_a(1, 1, 16'h0421);
    tick();
    idle_rx();
    tx_req = 1;
    tick();
    check("sup_txen", tx_en_a, 1);
    tx_req = 0;
    drive_b(1, 1, 16'h0C25);
    tick();
    idle_rx();
    check("sup_abort", abort, 1);
    check("sup_txen_a", tx_en_a, 0);
    check("sup_chan", active_chan, 1);
    check("sup_wd", word_data, 16'h0C25);
    check("sup_wv", word_valid, 1);
    check("sup_inh", {TX_INHIBIT_A, TX_INHIBIT_B}, 2'b11);
    check("sup_locked", locked, 1);
    tick();
    check("sup_abort_end", abort, 0);

    // bad-parity command on the other bus: dropped, no abort
    drive_a(1, 0, 16'hBAD0);
    tick();
    idle_rx();
    check("bad_abort", abort, 0);
    check("bad_wv", word_valid, 0);
    check("bad_chan", active_chan, 1);

    // good command on the locked bus in RX: plain forward
    drive_b(1, 1, 16'h0D00);
    tick();
    idle_rx();
    check("same_wv", word_valid, 1);
    check("same_wd", word_data, 16'h0D00);
    check("same_abort", abort, 0);
    check("same_chan", active_chan, 1);
`ifdef MKIO_ARB_STATS_EN
    check("st_abort", stat_abort, 1);
    check("st_drop", stat_drop, 2);
`endif

    // async reset mid-RX
    #2;
    reset = 0;
    #1;
    check_reset_outs("arst");
`ifdef MKIO_ARB_STATS_EN
    check("arst_stat", {stat_abort, stat_drop}, 32'd0);
`endif
    tick();
    reset = 1;
    tick();
    check("post_rst_lock", locked, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
